// File: rtl/exec_sequencer_if.sv
// Issue/ALU/write-back signal bundle for exec_sequencer.
// master = issuer + register file + ALU side, slave = the sequencer itself.
interface exec_sequencer_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [3:0]      alu_control;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_result;
   logic            wb_valid;
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            illegal;
   logic            busy;
   logic            halted;

   modport master (
      output in_valid, instr, rs1_data, rs2_data, alu_result,
      input  in_ready, alu_control, alu_a, alu_b,
      input  wb_valid, wb_we, wb_rd, wb_data, illegal, busy, halted
   );

   modport slave (
      input  in_valid, instr, rs1_data, rs2_data, alu_result,
      output in_ready, alu_control, alu_a, alu_b,
      output wb_valid, wb_we, wb_rd, wb_data, illegal, busy, halted
   );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle execute controller: one instruction in flight, single-cycle ALU ops,
// iterative shift-add MUL, one write-back pulse per retire, permanent halt on SYSTEM.
module exec_sequencer #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   exec_sequencer_if.slave   bus
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_EXEC = 3'd1;
   localparam logic [2:0] ST_MUL  = 3'd2;
   localparam logic [2:0] ST_WB   = 3'd3;
   localparam logic [2:0] ST_HALT = 3'd4;

   localparam logic [1:0] K_ALU  = 2'd0;
   localparam logic [1:0] K_MUL  = 2'd1;
   localparam logic [1:0] K_ILL  = 2'd2;
   localparam logic [1:0] K_HALT = 2'd3;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_MUL = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;

   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   logic [2:0]      state_reg;
   logic [2:0]      state_next;
   logic [3:0]      ctrl_reg;
   logic [XLEN-1:0] opa_reg;   // operand A / multiplicand
   logic [XLEN-1:0] opb_reg;   // operand B / multiplier
   logic [XLEN-1:0] acc_reg;   // ALU capture or MUL accumulator
   logic [CW-1:0]   cnt_reg;
   logic [4:0]      rd_reg;
   logic            ill_reg;

   logic            accept;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [1:0]      dec_kind;
   logic [3:0]      dec_ctrl;
   logic            dec_use_imm;
   logic [XLEN-1:0] dec_imm;

   assign accept = bus.in_valid && (state_reg == ST_IDLE);
   assign opcode = bus.instr[6:0];
   assign funct3 = bus.instr[14:12];
   assign funct7 = bus.instr[31:25];
   assign dec_imm = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};

   always_comb begin
      dec_kind    = K_ILL;
      dec_ctrl    = OP_AND;
      dec_use_imm = 1'b0;
      if (opcode == 7'h33 && funct7 == 7'h00) begin
         case (funct3)
            3'd0: begin dec_kind = K_ALU; dec_ctrl = OP_ADD; end
            3'd1: begin dec_kind = K_ALU; dec_ctrl = OP_SLL; end
            3'd2: begin dec_kind = K_MUL; dec_ctrl = OP_MUL; end
            3'd4: begin dec_kind = K_ALU; dec_ctrl = OP_XOR; end
            3'd5: begin dec_kind = K_ALU; dec_ctrl = OP_SRL; end
            3'd6: begin dec_kind = K_ALU; dec_ctrl = OP_OR;  end
            3'd7: begin dec_kind = K_ALU; dec_ctrl = OP_AND; end
            default: dec_kind = K_ILL;
         endcase
      end else if (opcode == 7'h33 && funct7 == 7'h20 && funct3 == 3'd0) begin
         dec_kind = K_ALU;
         dec_ctrl = OP_SUB;
      end else if (opcode == 7'h13 && funct3 == 3'd0) begin
         dec_kind    = K_ALU;
         dec_ctrl    = OP_ADD;
         dec_use_imm = 1'b1;
      end else if (opcode == 7'h73) begin
         dec_kind = K_HALT;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               case (dec_kind)
                  K_ALU:   state_next = ST_EXEC;
                  K_MUL:   state_next = ST_MUL;
                  K_HALT:  state_next = ST_HALT;
                  default: state_next = ST_WB;
               endcase
            end
         end
         ST_EXEC: state_next = ST_WB;
         ST_MUL:  if (cnt_reg == CNT_LAST) state_next = ST_WB;
         ST_WB:   state_next = ST_IDLE;
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         ctrl_reg  <= '0;
         opa_reg   <= '0;
         opb_reg   <= '0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         rd_reg    <= '0;
         ill_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  ctrl_reg <= dec_ctrl;
                  opa_reg  <= bus.rs1_data;
                  opb_reg  <= dec_use_imm ? dec_imm : bus.rs2_data;
                  acc_reg  <= '0;
                  cnt_reg  <= '0;
                  rd_reg   <= bus.instr[11:7];
                  ill_reg  <= (dec_kind == K_ILL);
               end
            end
            ST_EXEC: acc_reg <= bus.alu_result;
            ST_MUL: begin
               // One shift-add step; the sum wraps to XLEN bits by construction.
               if (opb_reg[0]) acc_reg <= acc_reg + opa_reg;
               opa_reg <= opa_reg << 1;
               opb_reg <= opb_reg >> 1;
               cnt_reg <= cnt_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // The shared ALU sees only zeros unless this sequencer owns it in EXEC.
   assign bus.alu_control = (state_reg == ST_EXEC) ? ctrl_reg : 4'b0000;
   assign bus.alu_a       = (state_reg == ST_EXEC) ? opa_reg  : '0;
   assign bus.alu_b       = (state_reg == ST_EXEC) ? opb_reg  : '0;

   assign bus.in_ready = (state_reg == ST_IDLE);
   assign bus.busy     = (state_reg == ST_EXEC) || (state_reg == ST_MUL) || (state_reg == ST_WB);
   assign bus.halted   = (state_reg == ST_HALT);
   assign bus.wb_valid = (state_reg == ST_WB);
   assign bus.wb_we    = (state_reg == ST_WB) && !ill_reg && (rd_reg != 5'd0);
   assign bus.wb_rd    = (state_reg == ST_WB) ? rd_reg : 5'd0;
   assign bus.wb_data  = ((state_reg == ST_WB) && !ill_reg) ? acc_reg : '0;
   assign bus.illegal  = (state_reg == ST_WB) && ill_reg;

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle execute controller between instruction issue and the register file. It accepts one decoded-format instruction at a time over a valid/ready handshake and drives the shared single-cycle ALU with operands and a 4-bit op code. MUL is run internally as an iterative shift-add over XLEN cycles. It emits one write-back pulse per retired instruction and stops permanently on SYSTEM opcode until reset.

Parameters:
XLEN, 32, datapath width; operand, result and multiplier iteration count.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  sequencer can accept; high only in IDLE
instr  in  32  RV32 instruction word
rs1_data  in  XLEN  register-file read port 1
rs2_data  in  XLEN  register-file read port 2
alu_control  out  4  op to shared ALU
alu_a  out  XLEN  ALU operand A
alu_b  out  XLEN  ALU operand B
alu_result  in  XLEN  combinational ALU result
wb_valid  out  1  one-cycle retire pulse
wb_we  out  1  register write enable, qualified by wb_valid
wb_rd  out  5  destination register
wb_data  out  XLEN  write-back data
illegal  out  1  one-cycle pulse with wb_valid when the instruction is unsupported
busy  out  1  high in any state other than IDLE or HALT
halted  out  1  sticky, high in HALT

Behaviour:
- Reset (async, rst_n low): state=IDLE; outputs in_ready=1 and halted=0; all other outputs 0. The MUL accumulator, multiplier and counter clear. Reset mid-MUL abandons the operation and produces no wb_valid.
- Accept occurs when in_valid && in_ready. On accept, register instr fields, rs1_data and rs2_data. Operand ports are sampled only at accept.
- Decode:
  - opcode 0x33, funct7=0x00:
    - funct3 0 -> ADD 0010
    - funct3 1 -> SLL 0011
    - funct3 4 -> XOR 0111
    - funct3 5 -> SRL 0101
    - funct3 6 -> OR 0001
    - funct3 7 -> AND 0000
  - opcode 0x33, funct3 0, funct7=0x20 -> SUB 0100.
  - opcode 0x33, funct3 2, funct7=0x00 -> MUL 0110, executed internally.
  - opcode 0x13, funct3 0 -> ADD with alu_b = sign-extended instr[31:20].
  - opcode 0x73 -> HALT.
  - Everything else is illegal.
- States:
  - IDLE -> EXEC (ALU op), MUL, WB (illegal), or HALT.
  - EXEC: 1 cycle. alu_control, alu_a and alu_b are driven from registers. alu_result is captured at the end of the cycle. -> WB.
  - MUL: exactly XLEN cycles. Each cycle: if the multiplier LSB is 1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1. Result is the low XLEN bits, with mod 2^XLEN wrap and no overflow flag. -> WB.
  - WB: wb_valid=1 for exactly one cycle. wb_rd=instr[11:7]. wb_we=1 unless illegal or rd==0. For illegal, wb_data=0 and illegal=1. -> IDLE.
  - HALT: halted=1 and in_ready=0 forever. Exit only via reset. No wb_valid is issued for the SYSTEM instruction.
- Latency, with accept at cycle t:
  - ALU op: wb_valid at t+2.
  - MUL: wb_valid at t+XLEN+1.
  - Illegal: wb_valid at t+1.
  - Next accept is possible in the cycle after WB (back-to-back ALU ops retire at most every 3 cycles).
- Outside EXEC, alu_control=0000 and alu_a=alu_b=0.
- in_valid while not ready is ignored; the issuer holds instr stable until accept.
- Shifts use the ALU's semantics; shift amount is rs2[4:0], formed by the ALU.

Test Plan:
1. Reset, then accept ADD x3,x1,x2 with rs1=5, rs2=7, ALU model returning 12 -> at t+1 alu_control=0010, alu_a=5, alu_b=7; at t+2 wb_valid=1, wb_rd=3, wb_we=1, wb_data=12.
2. SUB funct7=0x20 with rs1=3, rs2=5 -> alu_control=0100, wb_data=0xFFFFFFFE. ADDI x4,x0,-1 -> alu_b=0xFFFFFFFF, wb_rd=4.
3. MUL with rs1=0xFFFFFFFF, rs2=3 -> wb_valid exactly at t+33, wb_data=0xFFFFFFFD; in_ready=0 and busy=1 throughout.
4. ADD with rd=0 -> wb_valid=1, wb_we=0. Load opcode 0x03 -> wb_valid at t+1, illegal=1, wb_we=0, wb_data=0.
5. opcode 0x73 -> halted=1, in_ready=0; later in_valid pulses produce no wb_valid. rst_n low -> halted=0, in_ready=1.
6. rst_n asserted at MUL cycle 10 -> wb_valid never pulses. After release, ADD with rs1=1, rs2=1 retires 2 at t+2.
